// File: rtl/execute_stage_if.sv
// ID/EX -> EX/MEM bundle for the RV32IM execute stage.
// Upstream (master) drives *_pype1, keep and nop; execute_stage (slave) returns *_pype2 and ex_busy.
interface execute_stage_if;
  logic        keep;
  logic        nop;
  logic        ex_busy;

  logic [31:0] ALU_data1_pype1;
  logic [31:0] ALU_data2_pype1;
  logic [31:0] read_data2_pype1;
  logic [31:0] Imm_pype1;
  logic [31:0] PC_pype1;
  logic [4:0]  ALUop_pype1;
  logic        RegWrite_pype1;
  logic [2:0]  MemBranch_pype1;
  logic [1:0]  MemtoReg_pype1;
  logic [1:0]  MemRW_pype1;
  logic [1:0]  dsize_pype1;
  logic [4:0]  WReg_pype1;
  logic [2:0]  funct3_pype1;
  logic [6:0]  opcode_pype1;
  logic [31:0] Instraction_pype1;
  logic [1:0]  forwarding_stall_load_pyc_pype1;

  logic        RegWrite_pype2;
  logic [2:0]  MemBranch_pype2;
  logic [1:0]  MemtoReg_pype2;
  logic [1:0]  MemRW_pype2;
  logic [1:0]  dsize_pype2;
  logic [4:0]  WReg_pype2;
  logic [2:0]  funct3_pype2;
  logic [6:0]  opcode_pype2;
  logic [31:0] Instraction_pype2;
  logic [1:0]  forwarding_stall_load_pyc_pype2;
  logic [31:0] ALU_co_pype;
  logic [31:0] ALU_data1_pype2;
  logic [31:0] ALU_data2_pype2;
  logic [31:0] read_data2_pype2;
  logic [31:0] PCBranch_pype2;
  logic [31:0] PCp4_pype2;

  modport master (
    output keep, nop,
    output ALU_data1_pype1, ALU_data2_pype1, read_data2_pype1,
    output Imm_pype1, PC_pype1, ALUop_pype1, RegWrite_pype1,
    output MemBranch_pype1, MemtoReg_pype1, MemRW_pype1, dsize_pype1,
    output WReg_pype1, funct3_pype1, opcode_pype1, Instraction_pype1,
    output forwarding_stall_load_pyc_pype1,
    input  ex_busy,
    input  RegWrite_pype2, MemBranch_pype2, MemtoReg_pype2, MemRW_pype2,
    input  dsize_pype2, WReg_pype2, funct3_pype2, opcode_pype2,
    input  Instraction_pype2, forwarding_stall_load_pyc_pype2,
    input  ALU_co_pype, ALU_data1_pype2, ALU_data2_pype2,
    input  read_data2_pype2, PCBranch_pype2, PCp4_pype2
  );

  modport slave (
    input  keep, nop,
    input  ALU_data1_pype1, ALU_data2_pype1, read_data2_pype1,
    input  Imm_pype1, PC_pype1, ALUop_pype1, RegWrite_pype1,
    input  MemBranch_pype1, MemtoReg_pype1, MemRW_pype1, dsize_pype1,
    input  WReg_pype1, funct3_pype1, opcode_pype1, Instraction_pype1,
    input  forwarding_stall_load_pyc_pype1,
    output ex_busy,
    output RegWrite_pype2, MemBranch_pype2, MemtoReg_pype2, MemRW_pype2,
    output dsize_pype2, WReg_pype2, funct3_pype2, opcode_pype2,
    output Instraction_pype2, forwarding_stall_load_pyc_pype2,
    output ALU_co_pype, ALU_data1_pype2, ALU_data2_pype2,
    output read_data2_pype2, PCBranch_pype2, PCp4_pype2
  );
endinterface

// File: rtl/execute_stage.sv
// RV32IM execute stage: ALU, branch target, EX/MEM register
// and a multi-cycle shift-add / restoring-division MDU.
module execute_stage #(
  parameter bit FAST_MUL = 1'b1
) (
  input logic clk,
  input logic rst,
  execute_stage_if.slave ex
);
  typedef struct packed {
    logic        reg_write;
    logic [2:0]  mem_branch;
    logic [1:0]  mem_to_reg;
    logic [1:0]  mem_rw;
    logic [1:0]  dsize;
    logic [4:0]  wreg;
    logic [2:0]  funct3;
    logic [6:0]  opcode;
    logic [31:0] instr;
    logic [1:0]  fwd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
  } ctl_t;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [2:0]  f3_q, f3_d;
  logic        neg_q, neg_d;
  ctl_t        ctl_q, ctl_d;
  ctl_t        o_ctl_q, o_ctl_d;
  logic [31:0] o_res_q, o_res_d;
  logic [31:0] o_pcb_q, o_pcb_d;
  logic [31:0] o_pcp4_q, o_pcp4_d;

  ctl_t in_c;
  assign in_c = '{
    reg_write:  ex.RegWrite_pype1,
    mem_branch: ex.MemBranch_pype1,
    mem_to_reg: ex.MemtoReg_pype1,
    mem_rw:     ex.MemRW_pype1,
    dsize:      ex.dsize_pype1,
    wreg:       ex.WReg_pype1,
    funct3:     ex.funct3_pype1,
    opcode:     ex.opcode_pype1,
    instr:      ex.Instraction_pype1,
    fwd:        ex.forwarding_stall_load_pyc_pype1,
    a:          ex.ALU_data1_pype1,
    b:          ex.ALU_data2_pype1,
    rd2:        ex.read_data2_pype1,
    imm:        ex.Imm_pype1,
    pc:         ex.PC_pype1
  };

  logic [31:0] a, b, alu_res;
  logic [4:0]  op;
  logic [2:0]  mf3;
  logic        is_m, is_mul, fast;
  assign a      = ex.ALU_data1_pype1;
  assign b      = ex.ALU_data2_pype1;
  assign op     = ex.ALUop_pype1;
  assign mf3    = op[2:0];
  assign is_m   = (op[4:3] == 2'b10);
  assign is_mul = is_m & ~op[2];
  assign fast   = FAST_MUL & is_mul;

  always_comb begin
    alu_res = '0;
    case (op)
      5'd0:    alu_res = a + b;
      5'd1:    alu_res = a - b;
      5'd2:    alu_res = a << b[4:0];
      5'd3:    alu_res = {31'd0, $signed(a) < $signed(b)};
      5'd4:    alu_res = {31'd0, a < b};
      5'd5:    alu_res = a ^ b;
      5'd6:    alu_res = a >> b[4:0];
      5'd7:    alu_res = $signed(a) >>> b[4:0];
      5'd8:    alu_res = a | b;
      5'd9:    alu_res = a & b;
      5'd10:   alu_res = b;
      default: alu_res = '0;
    endcase
    // JALR target must be halfword aligned
    if (ex.opcode_pype1 == 7'b1100111) alu_res[0] = 1'b0;
  end

  logic        a_sg, b_sg, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  assign a_sg  = (mf3 == 3'b001) | (mf3 == 3'b010) |
                 (mf3 == 3'b100) | (mf3 == 3'b110);
  assign b_sg  = (mf3 == 3'b001) | (mf3 == 3'b100) | (mf3 == 3'b110);
  assign a_neg = a_sg & a[31];
  assign b_neg = b_sg & b[31];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // 64-bit modular product of sign-extended operands is exact in the low 64 bits
  logic [63:0] fx_a, fx_b, fx_p;
  logic [31:0] fast_res;
  assign fx_a     = {{32{a_neg}}, a};
  assign fx_b     = {{32{b_neg}}, b};
  assign fx_p     = fx_a * fx_b;
  assign fast_res = (mf3[1:0] == 2'b00) ? fx_p[31:0] : fx_p[63:32];

  logic [32:0] mul_sum, div_sh, div_sub;
  logic        div_ge;
  assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign div_sh  = {acc_q[63:32], acc_q[31]};
  assign div_sub = div_sh - {1'b0, opb_q};
  assign div_ge  = ~div_sub[32];

  logic [63:0] mul_p;
  logic [31:0] quo, rem, mdu_res;
  always_comb begin
    mul_p = neg_q ? -acc_q : acc_q;
    quo   = acc_q[31:0];
    rem   = acc_q[63:32];
    if (opb_q == '0) begin
      quo = '1;
      rem = ctl_q.a;
    end else if (!f3_q[0]) begin
      if (neg_q) quo = -quo;
      if (ctl_q.a[31]) rem = -rem;
    end
    if (!f3_q[2]) mdu_res = (f3_q[1:0] == 2'b00) ? mul_p[31:0] : mul_p[63:32];
    else          mdu_res = f3_q[1] ? rem : quo;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    ctl_d    = ctl_q;
    o_ctl_d  = o_ctl_q;
    o_res_d  = o_res_q;
    o_pcb_d  = o_pcb_q;
    o_pcp4_d = o_pcp4_q;
    if (!ex.keep) begin
      o_ctl_d  = '0;
      o_res_d  = '0;
      o_pcb_d  = '0;
      o_pcp4_d = '0;
      if (ex.nop) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (is_m && !fast) begin
              ctl_d   = in_c;
              f3_d    = mf3;
              neg_d   = a_neg ^ b_neg;
              cnt_d   = '0;
              // multiplier in acc low half; dividend shifted out of acc low half
              acc_d   = {32'd0, is_mul ? b_mag : a_mag};
              opb_d   = is_mul ? a_mag : b_mag;
              state_d = is_mul ? MUL_RUN : DIV_RUN;
            end else begin
              o_ctl_d  = in_c;
              o_res_d  = fast ? fast_res : alu_res;
              o_pcb_d  = in_c.pc + in_c.imm;
              o_pcp4_d = in_c.pc + 32'd4;
            end
          end
          MUL_RUN: begin
            acc_d = {mul_sum, acc_q[31:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = DONE;
          end
          DIV_RUN: begin
            acc_d = {div_ge ? div_sub[31:0] : div_sh[31:0], acc_q[30:0], div_ge};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = DONE;
          end
          DONE: begin
            o_ctl_d  = ctl_q;
            o_res_d  = mdu_res;
            o_pcb_d  = ctl_q.pc + ctl_q.imm;
            o_pcp4_d = ctl_q.pc + 32'd4;
            state_d  = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      ctl_q    <= '0;
      o_ctl_q  <= '0;
      o_res_q  <= '0;
      o_pcb_q  <= '0;
      o_pcp4_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      ctl_q    <= ctl_d;
      o_ctl_q  <= o_ctl_d;
      o_res_q  <= o_res_d;
      o_pcb_q  <= o_pcb_d;
      o_pcp4_q <= o_pcp4_d;
    end
  end

  assign ex.ex_busy                         = (state_q != IDLE);
  assign ex.RegWrite_pype2                  = o_ctl_q.reg_write;
  assign ex.MemBranch_pype2                 = o_ctl_q.mem_branch;
  assign ex.MemtoReg_pype2                  = o_ctl_q.mem_to_reg;
  assign ex.MemRW_pype2                     = o_ctl_q.mem_rw;
  assign ex.dsize_pype2                     = o_ctl_q.dsize;
  assign ex.WReg_pype2                      = o_ctl_q.wreg;
  assign ex.funct3_pype2                    = o_ctl_q.funct3;
  assign ex.opcode_pype2                    = o_ctl_q.opcode;
  assign ex.Instraction_pype2               = o_ctl_q.instr;
  assign ex.forwarding_stall_load_pyc_pype2 = o_ctl_q.fwd;
  assign ex.ALU_co_pype                     = o_res_q;
  assign ex.ALU_data1_pype2                 = o_ctl_q.a;
  assign ex.ALU_data2_pype2                 = o_ctl_q.b;
  assign ex.read_data2_pype2                = o_ctl_q.rd2;
  assign ex.PCBranch_pype2                  = o_pcb_q;
  assign ex.PCp4_pype2                      = o_pcp4_q;
endmodule

// File: tb/tb_execute_stage.sv
// Directed + randomized bench for execute_stage (iterative MDU build),
// checked against an arithmetic reference model.
module tb_execute_stage;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;

  execute_stage_if bus();

  execute_stage #(.FAST_MUL(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .ex (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] e_a, e_pc, e_instr;
  logic        e_rw;
  logic [4:0]  e_wreg;
  logic [1:0]  e_mrw;
  logic [2:0]  e_mb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [6:0] opc);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a << b[4:0];
      5'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  r = (a < b) ? 32'd1 : 32'd0;
      5'd5:  r = a ^ b;
      5'd6:  r = a >> b[4:0];
      5'd7:  r = 32'($signed(a) >>> b[4:0]);
      5'd8:  r = a | b;
      5'd9:  r = a & b;
      5'd10: r = b;
      5'd16: r = 32'(sa * sb);
      5'd17: r = 32'((sa * sb) >>> 32);
      5'd18: r = 32'((sa * longint'(ub)) >>> 32);
      5'd19: r = 32'((ua * ub) >> 32);
      5'd20: r = (b == 0) ? 32'hFFFFFFFF :
                 (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : 32'(sa / sb);
      5'd21: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      5'd22: r = (b == 0) ? a :
                 (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(sa % sb);
      5'd23: r = (b == 0) ? a : a % b;
      default: r = 32'd0;
    endcase
    if (op == 5'd0 && opc == 7'b1100111) r[0] = 1'b0;
    return r;
  endfunction

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] opc);
    e_a     = a;
    e_pc    = $urandom;
    e_instr = $urandom | 32'd1;
    e_rw    = 1'b1;
    e_wreg  = 5'($urandom_range(1, 31));
    e_mrw   = 2'($urandom_range(1, 3));
    e_mb    = 3'($urandom_range(1, 7));
    bus.ALUop_pype1                     = op;
    bus.ALU_data1_pype1                 = a;
    bus.ALU_data2_pype1                 = b;
    bus.read_data2_pype1                = $urandom;
    bus.Imm_pype1                       = $urandom;
    bus.PC_pype1                        = e_pc;
    bus.RegWrite_pype1                  = e_rw;
    bus.MemBranch_pype1                 = e_mb;
    bus.MemtoReg_pype1                  = 2'($urandom);
    bus.MemRW_pype1                     = e_mrw;
    bus.dsize_pype1                     = 2'($urandom);
    bus.WReg_pype1                      = e_wreg;
    bus.funct3_pype1                    = 3'($urandom);
    bus.opcode_pype1                    = opc;
    bus.Instraction_pype1               = e_instr;
    bus.forwarding_stall_load_pyc_pype1 = 2'($urandom);
  endtask

  function automatic logic [31:0] ctl_now();
    return {21'd0, bus.RegWrite_pype2, bus.WReg_pype2, bus.MemRW_pype2, bus.MemBranch_pype2};
  endfunction

  function automatic logic [31:0] ctl_exp();
    return {21'd0, e_rw, e_wreg, e_mrw, e_mb};
  endfunction

  task automatic alu_step(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [6:0] opc, input logic [31:0] want);
    logic [31:0] imm;
    drive(op, a, b, opc);
    imm = bus.Imm_pype1;
    @(posedge clk); #1;
    check(tag, bus.ALU_co_pype, want);
    check({tag, ".ctl"}, ctl_now(), ctl_exp());
    check({tag, ".pcb"}, bus.PCBranch_pype2, e_pc + imm);
    check({tag, ".pcp4"}, bus.PCp4_pype2, e_pc + 32'd4);
  endtask

  task automatic run_m(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int keep_at, input logic [31:0] want,
                       input int exp_edges);
    int n;
    int hi;
    int bub;
    n = 0; hi = 0; bub = 0;
    drive(op, a, b, 7'b0110011);
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        bus.ALU_data1_pype1 = $urandom;
        bus.ALU_data2_pype1 = $urandom;
      end
      if (keep_at > 0 && n == keep_at) bus.keep = 1'b1;
      if (keep_at > 0 && n == keep_at + 3) bus.keep = 1'b0;
      if (bus.ex_busy) begin
        hi++;
        if (bus.RegWrite_pype2 || bus.WReg_pype2 != 0 ||
            bus.Instraction_pype2 != 0 || bus.MemRW_pype2 != 0) bub++;
      end
    end while (bus.ex_busy && n < 200);
    bus.keep = 1'b0;
    bus.ALUop_pype1 = 5'd0;
    check({tag, ".edges"}, 32'(n), 32'(exp_edges));
    check({tag, ".busy"}, 32'(hi), 32'(exp_edges - 1));
    check({tag, ".bubble"}, 32'(bub), 32'd0);
    check(tag, bus.ALU_co_pype, want);
    check({tag, ".ctl"}, ctl_now(), ctl_exp());
    check({tag, ".opa"}, bus.ALU_data1_pype2, e_a);
    check({tag, ".pcp4"}, bus.PCp4_pype2, e_pc + 32'd4);
  endtask

  initial begin
    logic [31:0] ra, rb, held;
    logic [4:0]  rop;
    rst = 1'b1;
    bus.keep = 1'b0;
    bus.nop  = 1'b0;
    drive(5'd0, 32'd0, 32'd0, 7'b0110011);
    #12;
    check("rst.co", bus.ALU_co_pype, 32'd0);
    check("rst.busy", {31'd0, bus.ex_busy}, 32'd0);
    check("rst.ctl", ctl_now(), 32'd0);
    check("rst.pcp4", bus.PCp4_pype2, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    alu_step("add_ovf", 5'd0, 32'h7FFFFFFF, 32'd1, 7'b0110011, 32'h80000000);
    alu_step("sra31", 5'd7, 32'h80000000, 32'd31, 7'b0110011, 32'hFFFFFFFF);
    alu_step("sltu", 5'd4, 32'd1, 32'hFFFFFFFF, 7'b0110011, 32'd1);
    alu_step("slt", 5'd3, 32'd1, 32'hFFFFFFFF, 7'b0110011, 32'd0);
    alu_step("sub", 5'd1, 32'd5, 32'd7, 7'b1100011, 32'hFFFFFFFE);
    alu_step("jalr", 5'd0, 32'h00001001, 32'd4, 7'b1100111, 32'h00001004);
    alu_step("pass_b", 5'd10, 32'hDEADBEEF, 32'h12345678, 7'b0110111, 32'h12345678);

    for (int i = 0; i < 24; i++) begin
      rop = 5'($urandom_range(0, 10));
      ra  = $urandom;
      rb  = $urandom;
      alu_step("alu_rand", rop, ra, rb, 7'b0110011, model(rop, ra, rb, 7'b0110011));
    end

    held = bus.ALU_co_pype;
    bus.keep = 1'b1;
    drive(5'd0, 32'd3, 32'd4, 7'b0110011);
    @(posedge clk); #1;
    check("keep_idle", bus.ALU_co_pype, held);
    bus.keep = 1'b0;

    run_m("div", 5'd20, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFD, 34);
    run_m("rem", 5'd22, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFF, 34);
    run_m("divu0", 5'd21, 32'd5, 32'd0, 0, 32'hFFFFFFFF, 34);
    run_m("remu0", 5'd23, 32'd5, 32'd0, 0, 32'd5, 34);
    run_m("div_ovf", 5'd20, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 34);
    run_m("rem_ovf", 5'd22, 32'h80000000, 32'hFFFFFFFF, 0, 32'd0, 34);
    run_m("mulh", 5'd17, 32'h80000000, 32'h80000000, 0, 32'h40000000, 34);
    run_m("mulh_keep", 5'd17, 32'h80000000, 32'h80000000, 10, 32'h40000000, 37);
    run_m("mul", 5'd16, 32'hFFFFFFFD, 32'd7, 0, 32'hFFFFFFEB, 34);

    for (int i = 0; i < 10; i++) begin
      rop = 5'($urandom_range(16, 23));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      run_m("mdu_rand", rop, ra, rb, 0, model(rop, ra, rb, 7'b0110011), 34);
    end

    drive(5'd21, $urandom, $urandom, 7'b0110011);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
    end
    check("nop.pre_busy", {31'd0, bus.ex_busy}, 32'd1);
    bus.nop = 1'b1;
    @(posedge clk); #1;
    bus.nop = 1'b0;
    check("nop.busy", {31'd0, bus.ex_busy}, 32'd0);
    check("nop.ctl", ctl_now(), 32'd0);
    check("nop.instr", bus.Instraction_pype2, 32'd0);
    alu_step("after_nop", 5'd0, 32'd100, 32'd23, 7'b0110011, 32'd123);

    drive(5'd19, $urandom, $urandom, 7'b0110011);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    check("rst_mid.pre_busy", {31'd0, bus.ex_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid.busy", {31'd0, bus.ex_busy}, 32'd0);
    check("rst_mid.co", bus.ALU_co_pype, 32'd0);
    check("rst_mid.ctl", ctl_now(), 32'd0);
    check("rst_mid.pcb", bus.PCBranch_pype2, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    alu_step("after_rst", 5'd8, 32'hF0F00000, 32'h0000F0F0, 7'b0110011, 32'hF0F0F0F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
